// File: rtl/dmem_responder_if.sv
// CPU data-port bus plus the TX byte stream, bundled for the data-memory responder.
interface dmem_responder_if;
    logic [31:0] data_addr;
    logic [31:0] data_rd;
    logic [31:0] data_wr;
    logic [3:0]  data_wr_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave (
        input  data_addr, data_wr, data_wr_en, tx_ready,
        output data_rd, tx_data, tx_valid
    );

    modport master (
        output data_addr, data_wr, data_wr_en, tx_ready,
        input  data_rd, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte enables plus MMIO (LED, TX FIFO, STATUS, CYCLE).
// Define DMEM_CYCLE_COUNTER_EN to build the free-running CYCLE register; otherwise CYCLE reads 0.
module dmem_responder #(
    parameter int DEPTH    = 1024,
    parameter int TX_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    output logic [7:0]       led
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(TX_DEPTH);

    // lane alignment: lanes shifted past byte 3 fall off rather than wrapping
    logic [1:0]  off;
    logic [3:0]  eff_en;
    logic [31:0] eff_data;
    assign off      = bus.data_addr[1:0];
    assign eff_en   = bus.data_wr_en << off;
    assign eff_data = bus.data_wr << {off, 3'b000};

    logic          mmio;
    logic [1:0]    sel;
    logic [AW-1:0] idx;
    assign mmio = bus.data_addr[31];
    assign sel  = bus.data_addr[3:2];
    assign idx  = bus.data_addr[AW+1:2];

    logic unused_addr;
    assign unused_addr = ^bus.data_addr[30:AW+2];

    // ---------------- RAM ----------------
    logic [31:0] mem [DEPTH];

    // RAM writes are deliberately not gated by rst
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!mmio && eff_en[i])
                mem[idx][8*i +: 8] <= eff_data[8*i +: 8];
        end
    end

    // ---------------- MMIO decode ----------------
    logic led_we, push, ovf_clr;
    assign led_we  = mmio && (sel == 2'd0) && eff_en[0];
    assign push    = mmio && (sel == 2'd1) && eff_en[0];
    assign ovf_clr = mmio && (sel == 2'd2) && eff_en[0] && eff_data[2];

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo [TX_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          empty, full, pop, push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign pop     = bus.tx_valid && bus.tx_ready;
    // a full FIFO still takes a byte when the head leaves in the same cycle
    assign push_ok = push && (!full || pop);

    assign bus.tx_valid = !empty;
    assign bus.tx_data  = empty ? 8'h00 : fifo[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo[wr_ptr] <= eff_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            led    <= 8'h00;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !push_ok)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
            if (led_we)
                led <= eff_data[7:0];
        end
    end

    // ---------------- cycle counter ----------------
    logic [31:0] cycle_cnt;
`ifdef DMEM_CYCLE_COUNTER_EN
    always_ff @(posedge clk) begin
        if (rst)
            cycle_cnt <= '0;
        else
            cycle_cnt <= cycle_cnt + 32'd1;
    end
`else
    assign cycle_cnt = '0;
`endif

    // ---------------- read mux ----------------
    logic [7:0] cnt8;
    assign cnt8 = 8'(count);

    always_comb begin
        bus.data_rd = '0;
        if (!mmio) begin
            bus.data_rd = mem[idx];
        end else begin
            case (sel)
                2'd0:    bus.data_rd = {24'h0, led};
                2'd1:    bus.data_rd = '0;
                2'd2:    bus.data_rd = {16'h0, cnt8, 5'h0, ovf, empty, full};
                default: bus.data_rd = cycle_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: RAM lanes, MMIO regs, TX FIFO ordering/overflow, reset, CYCLE.
module tb_dmem_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] led;

    dmem_responder_if dif();

    dmem_responder #(.DEPTH(1024), .TX_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave),
        .led (led)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] en);
        dif.data_addr  = addr;
        dif.data_wr    = data;
        dif.data_wr_en = en;
        step();
        dif.data_wr_en = 4'h0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        dif.data_addr  = addr;
        dif.data_wr_en = 4'h0;
        @(negedge clk);
        data = dif.data_rd;
        step();
    endtask

    // FIFO scoreboard: pushes enqueued as driven, pops compared as the sink accepts
    always @(negedge clk) begin : mon
        int n;
        bit popped;
        n = exp_q.size();
        popped = 1'b0;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (n != 0 && dif.tx_ready) begin
                chk("tx_valid_pop", 32'(dif.tx_valid), 32'd1);
                chk("tx_data", 32'(dif.tx_data), 32'(exp_q.pop_front()));
                popped = 1'b1;
            end
            if (dif.data_addr[31] && dif.data_addr[3:2] == 2'd1 &&
                dif.data_addr[1:0] == 2'd0 && dif.data_wr_en[0]) begin
                if (n < 4 || popped) exp_q.push_back(dif.data_wr[7:0]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    localparam logic [31:0] A_LED  = 32'h8000_0000;
    localparam logic [31:0] A_TX   = 32'h8000_0004;
    localparam logic [31:0] A_STAT = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_000C;

    initial begin
        logic [31:0] r, c1, c2;
        rst            = 1'b1;
        dif.data_addr  = '0;
        dif.data_wr    = '0;
        dif.data_wr_en = 4'h0;
        dif.tx_ready   = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        chk("rst_led", 32'(led), 32'h0);
        chk("rst_tx_valid", 32'(dif.tx_valid), 32'h0);
        chk("rst_tx_data", 32'(dif.tx_data), 32'h0);
        bus_rd(A_STAT, r); chk("rst_status", r, 32'h2);

        // byte lanes
        bus_wr(32'h10, 32'hDEADBEEF, 4'hF);
        bus_wr(32'h12, 32'h55, 4'h1);
        bus_rd(32'h10, r); chk("sb_merge", r, 32'hDE55BEEF);

        bus_wr(32'h0, 32'h0, 4'hF);
        bus_wr(32'h4, 32'h11223344, 4'hF);
        bus_wr(32'h3, 32'hABCD, 4'h3);
        bus_rd(32'h0, r); chk("sh_drop", r, 32'hCD000000);
        bus_rd(32'h4, r); chk("sh_next", r, 32'h11223344);

        // read-during-write shows the old word
        dif.data_addr  = 32'h0;
        dif.data_wr    = 32'hCAFEF00D;
        dif.data_wr_en = 4'hF;
        @(negedge clk);
        chk("rdw_old", dif.data_rd, 32'hCD000000);
        step();
        dif.data_wr_en = 4'h0;
        bus_rd(32'h0, r); chk("rdw_new", r, 32'hCAFEF00D);

        // overflow
        for (int i = 0; i < 5; i++) bus_wr(A_TX, 32'(i) + 32'h41, 4'h1);
        bus_rd(A_STAT, r); chk("stat_ovf_full", r, 32'h405);
        dif.tx_ready = 1'b1;
        repeat (4) step();
        dif.tx_ready = 1'b0;
        chk("drained_valid", 32'(dif.tx_valid), 32'h0);
        bus_rd(A_STAT, r); chk("stat_empty_ovf", r, 32'h6);
        bus_wr(A_STAT, 32'h4, 4'h1);
        bus_rd(A_STAT, r); chk("stat_ovf_clr", r, 32'h2);
        bus_rd(A_TX, r); chk("txdata_rd0", r, 32'h0);

        // push into full FIFO while popping
        for (int i = 0; i < 4; i++) bus_wr(A_TX, 32'(i) + 32'h61, 4'h1);
        bus_rd(A_STAT, r); chk("stat_full", r, 32'h401);
        dif.tx_ready = 1'b1;
        bus_wr(A_TX, 32'h5A, 4'h1);
        dif.tx_ready = 1'b0;
        bus_rd(A_STAT, r); chk("stat_full_pushpop", r, 32'h401);
        dif.tx_ready = 1'b1;
        repeat (4) step();
        dif.tx_ready = 1'b0;
        chk("drained2_valid", 32'(dif.tx_valid), 32'h0);

        // LED, including an unaligned write that misses lane 0
        bus_wr(A_LED, 32'hA5, 4'h1);
        chk("led_wr", 32'(led), 32'hA5);
        bus_wr(A_LED + 32'h1, 32'h3C, 4'h1);
        chk("led_unaligned", 32'(led), 32'hA5);
        bus_rd(A_LED, r); chk("led_rd", r, 32'hA5);

        // reset: MMIO writes ignored, RAM writes committed, FIFO flushed
        bus_wr(32'h20, 32'h12345678, 4'hF);
        bus_wr(A_TX, 32'h99, 4'h1);
        chk("pre_rst_valid", 32'(dif.tx_valid), 32'h1);
        rst = 1'b1;
        bus_wr(A_LED, 32'hFF, 4'h1);
        bus_wr(32'h24, 32'h9, 4'hF);
        rst = 1'b0;
        chk("rst2_led", 32'(led), 32'h0);
        chk("rst2_tx_valid", 32'(dif.tx_valid), 32'h0);
        chk("rst2_tx_data", 32'(dif.tx_data), 32'h0);
        bus_rd(A_CYC, r); chk("rst2_cycle", r, 32'h0);
        bus_rd(32'h20, r); chk("rst2_ram_keep", r, 32'h12345678);
        bus_rd(32'h24, r); chk("rst2_ram_wr", r, 32'h9);
        bus_rd(A_STAT, r); chk("rst2_status", r, 32'h2);

        // cycle counter
        bus_rd(A_CYC, c1);
        repeat (9) step();
        bus_rd(A_CYC, c2);
`ifdef DMEM_CYCLE_COUNTER_EN
        chk("cycle_diff", c2 - c1, 32'd10);
`else
        chk("cycle_c1_zero", c1, 32'h0);
        chk("cycle_c2_zero", c2, 32'h0);
`endif

        // aliasing
        bus_wr(32'h0000_1000, 32'h77, 4'hF);
        bus_rd(32'h0, r); chk("ram_alias", r, 32'h77);
        bus_wr(A_LED, 32'h3C, 4'h1);
        bus_rd(32'hFFFF_FFF0, r); chk("mmio_alias", r, 32'h3C);

        step();
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
